car_lamp_ctrl: RTL and testbench
================================

Name: car_lamp_ctrl

Overview:
Parametrised successor to the fixed 3-LED car lamp controller. Drives left and right sequential turn-lamp bars of LAMP_W LEDs each, with brake, hazard and door-open countdown modes, from one system clock. Includes an internal step prescaler, a door-open seconds countdown shown on two 7-segment digits, and an alarm flag. Sits directly under the board top level, between the debounced switch inputs and the LED/segment pins.

Parameters:
LAMP_W, 3, LEDs per side (2..16)
TICK_DIV, 5_000_000, clk cycles per lamp step/blink tick (>=2)
SEC_DIV, 50_000_000, clk cycles per countdown second (>=2)
DOOR_SECS, 10, countdown start value in seconds (1..99)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
turn_l  in  1  left turn request, level
turn_r  in  1  right turn request, level
brake  in  1  brake pedal, level
door  in  1  door open, level
led_l  out  LAMP_W  left bar; bit0 nearest centre
led_r  out  LAMP_W  right bar; bit0 nearest centre
seg_tens  out  7  tens digit, active-high, bit order {g,f,e,d,c,b,a}
seg_ones  out  7  ones digit, same encoding
door_alarm  out  1  countdown expired while door open

Behaviour:
- Reset: one clock, async active-high reset; while rst is high all outputs are 0, all counters are 0 and both side modes are OFF.
- Side mode, decided each cycle from the inputs, highest priority first:
  - turn_l&turn_r: both sides BLINK.
  - Exactly one turn: that side FLOW; other side SOLID if brake, else OFF.
  - Brake only: both SOLID.
  - Otherwise: both OFF.
- Mode registers mode_l/mode_r are updated every edge. All outputs are registered, so an input change appears on the outputs 1 cycle later.
- Tick prescaler: cnt counts 0..TICK_DIV-1 and tick=1 when cnt==TICK_DIV-1. cnt clears to 0 on any edge where either side's mode changes.
- FLOW, per-side phase p in 0..LAMP_W; led = (1<<p)-1.
  - On mode entry p=1, so one LED lights at latency 1.
  - On each tick p advances: p==LAMP_W -> 0, otherwise p+1. Cycle length is LAMP_W+1 ticks.
- BLINK: per-side phase bit b=1 on entry (all LEDs on); b toggles each tick; led = b ? all-ones : 0. Both sides share the same b, so they stay in sync.
- SOLID: led all-ones. OFF: led 0.
- Any mode change restarts that side's phase at its entry value; there is no carry-over between modes.
- Door countdown:
  - door low: rem=DOOR_SECS, sec counter=0, segments blank (7'b0), door_alarm=0.
  - door high: sec counter counts 0..SEC_DIV-1; at SEC_DIV-1 it wraps and rem decrements, saturating at 0.
  - Display shows rem: tens=rem/10, ones=rem%10, tens shown even if 0.
  - door_alarm=1 while door high and rem==0.
  - Door dropping mid-countdown clears everything on the next edge; re-opening restarts from DOOR_SECS.
- Segment codes: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Door logic is independent of the lamp modes; both operate simultaneously.
- Width rules: cnt is $clog2(TICK_DIV) bits, the sec counter $clog2(SEC_DIV) bits, rem 7 bits, p $clog2(LAMP_W+1) bits.

Decomposition:
- Shared package car_lamp_pkg: mode enum {MODE_OFF, MODE_FLOW, MODE_SOLID, MODE_BLINK}; SEG_BLANK constant; the digit-to-segment constant table.
- One natural sub-module, seg7_decode: 4-bit digit -> 7-bit segments, combinational, instantiated twice.
- Per-side phase logic stays inline, or in a generate loop over the two sides.

Test Plan:
(bench params: LAMP_W=4, TICK_DIV=4, SEC_DIV=8, DOOR_SECS=3; clk period 20)
1. Assert rst mid-operation with door high and turn_l active -> all outputs 0 immediately, without waiting for an edge; after release, led_l=0001 at 1 cycle latency once turn_l is sampled.
2. turn_l=1 from idle -> next cycle led_l=0001, led_r=0000; then every 4 cycles 0011, 0111, 1111, 0000, 0001.
3. turn_l=turn_r=1 -> next cycle led_l=led_r=1111; 4 cycles later both 0000; alternating every 4 cycles thereafter.
4. brake=1 with turn_r=1 -> led_l=1111 constant; led_r flows 0001, 0011, ... Dropping brake -> led_l=0000 next cycle, with led_r phase restarting at 0001.
5. door=1 -> seg_tens=0111111, seg_ones=1001111 ("03"); after 8 cycles "02", after 16 "01", after 24 "00" and door_alarm=1, held. door=0 -> segments 0000000 and door_alarm=0 next cycle.
6. Flow reaches 0111, then turn_l drops and rises again in 2 cycles -> led_l restarts at 0001, and the prescaler restarts a full 4 cycles.

Source files
------------

// File: rtl/car_lamp_pkg.sv
// car_lamp_pkg: shared types and constants for the car lamp controller.
//   mode_e    : per-side lamp mode
//   SEG_BLANK : all segments off
//   SEG_TABLE : digit 0..9 -> 7-segment code, active-high, bit order {g,f,e,d,c,b,a}
package car_lamp_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_FLOW  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

endpackage

// File: rtl/car_lamp_ctrl_seg7_decode.sv
// seg7_decode: combinational BCD digit to 7-segment decoder.
//   digit : 4-bit value; 0..9 decode through SEG_TABLE, anything else is blank
//   seg   : 7-bit segment pattern {g,f,e,d,c,b,a}, active-high
module seg7_decode
  import car_lamp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) begin
        seg = SEG_TABLE[i];
      end
    end
  end

endmodule

// File: rtl/car_lamp_ctrl.sv
// car_lamp_ctrl: sequential turn / brake / hazard lamp controller with a
// door-open seconds countdown on two 7-segment digits.
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-high
//   turn_l     : left turn request (level)
//   turn_r     : right turn request (level)
//   brake      : brake pedal (level)
//   door       : door open (level)
//   led_l      : left bar, LAMP_W LEDs, bit0 nearest centre
//   led_r      : right bar, LAMP_W LEDs, bit0 nearest centre
//   seg_tens   : tens digit of the remaining seconds (blank while door closed)
//   seg_ones   : ones digit of the remaining seconds (blank while door closed)
//   door_alarm : countdown reached zero while the door is still open
// All outputs are registered: an input change shows up one clock later.
module car_lamp_ctrl
  import car_lamp_pkg::*;
#(
  parameter int LAMP_W    = 3,
  parameter int TICK_DIV  = 5_000_000,
  parameter int SEC_DIV   = 50_000_000,
  parameter int DOOR_SECS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              turn_l,
  input  logic              turn_r,
  input  logic              brake,
  input  logic              door,
  output logic [LAMP_W-1:0] led_l,
  output logic [LAMP_W-1:0] led_r,
  output logic [6:0]        seg_tens,
  output logic [6:0]        seg_ones,
  output logic              door_alarm
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SEC_DIV);
  localparam int PW = $clog2(LAMP_W + 1);

  localparam logic [CW-1:0] TICK_MAX    = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_MAX     = SW'(SEC_DIV - 1);
  localparam logic [PW-1:0] PHASE_MAX   = PW'(LAMP_W);
  localparam logic [PW-1:0] PHASE_ENTRY = PW'(1);
  localparam logic [6:0]    REM_START   = 7'(DOOR_SECS);

  // ---------------------------------------------------------------------
  // Lamp step prescaler, shared by both sides so hazard blinking stays in
  // lock-step. Any mode change on either side restarts it.
  // ---------------------------------------------------------------------
  logic [1:0]    turn;
  logic [1:0]    side_chg;
  logic [CW-1:0] cnt_reg;
  logic          tick;

  assign turn = {turn_r, turn_l};
  assign tick = (cnt_reg == TICK_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if ((|side_chg) || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-side mode and phase. gi=0 is the left side, gi=1 the right side.
  // The phase register doubles as the FLOW position (0..LAMP_W) and, in
  // BLINK, as the on/off bit in bit 0. Both start at 1 on mode entry.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : side
      mode_e             mode_reg, mode_next;
      logic [PW-1:0]     phase_reg, phase_next;
      logic [LAMP_W-1:0] led_reg, led_next;

      // Both turns -> hazard; own turn -> flow; otherwise brake decides.
      always_comb begin
        mode_next = MODE_OFF;
        if (&turn) begin
          mode_next = MODE_BLINK;
        end else if (turn[gi]) begin
          mode_next = MODE_FLOW;
        end else if (brake) begin
          mode_next = MODE_SOLID;
        end
      end

      assign side_chg[gi] = (mode_next != mode_reg);

      always_comb begin
        phase_next = phase_reg;
        if (side_chg[gi]) begin
          phase_next = PHASE_ENTRY;
        end else if (tick) begin
          case (mode_reg)
            MODE_FLOW:  phase_next = (phase_reg == PHASE_MAX) ? '0 : phase_reg + 1'b1;
            MODE_BLINK: phase_next = phase_reg ^ PHASE_ENTRY;
            default:    phase_next = phase_reg;
          endcase
        end

        // LED image is built from the next state so it lands in the
        // output register on the same edge as the mode/phase update.
        led_next = '0;
        case (mode_next)
          MODE_SOLID: led_next = '1;
          MODE_BLINK: led_next = {LAMP_W{phase_next[0]}};
          MODE_FLOW: begin
            // Thermometer fill: the phase_next LEDs nearest centre are lit.
            for (int i = 0; i < LAMP_W; i++) begin
              led_next[i] = (PW'(i) < phase_next);
            end
          end
          default:    led_next = '0;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mode_reg  <= MODE_OFF;
          phase_reg <= '0;
          led_reg   <= '0;
        end else begin
          mode_reg  <= mode_next;
          phase_reg <= phase_next;
          led_reg   <= led_next;
        end
      end
    end
  endgenerate

  assign led_l = side[0].led_reg;
  assign led_r = side[1].led_reg;

  // ---------------------------------------------------------------------
  // Door countdown. door_act_reg remembers whether the previous edge saw
  // the door open; when it did not (door closed, or just out of reset) the
  // countdown is treated as starting fresh from DOOR_SECS.
  // ---------------------------------------------------------------------
  logic          door_act_reg;
  logic [SW-1:0] sec_reg, sec_next;
  logic [6:0]    rem_reg, rem_cur, rem_next;
  logic [3:0]    tens_digit, ones_digit;
  logic [6:0]    tens_seg, ones_seg;

  always_comb begin
    rem_cur  = door_act_reg ? rem_reg : REM_START;
    sec_next = '0;
    rem_next = REM_START;
    if (door) begin
      if (sec_reg == SEC_MAX) begin
        sec_next = '0;
        rem_next = (rem_cur == 7'd0) ? 7'd0 : rem_cur - 7'd1;
      end else begin
        sec_next = sec_reg + 1'b1;
        rem_next = rem_cur;
      end
    end
  end

  assign tens_digit = 4'(rem_next / 7'd10);
  assign ones_digit = 4'(rem_next % 7'd10);

  seg7_decode u_seg_tens (
    .digit (tens_digit),
    .seg   (tens_seg)
  );

  seg7_decode u_seg_ones (
    .digit (ones_digit),
    .seg   (ones_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_act_reg <= 1'b0;
      sec_reg      <= '0;
      rem_reg      <= '0;
      seg_tens     <= SEG_BLANK;
      seg_ones     <= SEG_BLANK;
      door_alarm   <= 1'b0;
    end else begin
      door_act_reg <= door;
      sec_reg      <= sec_next;
      rem_reg      <= rem_next;
      seg_tens     <= door ? tens_seg : SEG_BLANK;
      seg_ones     <= door ? ones_seg : SEG_BLANK;
      door_alarm   <= door && (rem_next == 7'd0);
    end
  end

endmodule

// File: tb/tb_car_lamp_ctrl.sv
// tb_car_lamp_ctrl: directed scenarios plus randomized traffic for
// car_lamp_ctrl, compared every cycle against a behavioural model that
// works in terms of "ticks elapsed since the mode was entered" and
// "seconds elapsed since the door opened".
module tb_car_lamp_ctrl;

  localparam int LW = 4;
  localparam int TD = 4;
  localparam int SD = 8;
  localparam int DS = 3;
  localparam int ALL_ON = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          turn_l = 1'b0;
  logic          turn_r = 1'b0;
  logic          brake = 1'b0;
  logic          door = 1'b0;
  logic [LW-1:0] led_l;
  logic [LW-1:0] led_r;
  logic [6:0]    seg_tens;
  logic [6:0]    seg_ones;
  logic          door_alarm;

  car_lamp_ctrl #(
    .LAMP_W    (LW),
    .TICK_DIV  (TD),
    .SEC_DIV   (SD),
    .DOOR_SECS (DS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .turn_l     (turn_l),
    .turn_r     (turn_r),
    .brake      (brake),
    .door       (door),
    .led_l      (led_l),
    .led_r      (led_r),
    .seg_tens   (seg_tens),
    .seg_ones   (seg_ones),
    .door_alarm (door_alarm)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model. Modes: 0 off, 1 flow, 2 solid, 3 blink.
  // ------------------------------------------------------------------
  int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  int m_mode [2];
  int m_k    [2];   // ticks seen since this side entered its mode
  int m_age;        // edges since the prescaler last restarted
  int m_door_e;     // consecutive door-open edges
  int e_led  [2];
  int e_tens, e_ones, e_alarm;

  function automatic int want_mode(input int s, input logic tl, input logic tr, input logic br);
    logic own;
    own = (s == 0) ? tl : tr;
    if (tl && tr) return 3;
    if (own)      return 1;
    if (br)       return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_mode[s] = 0;
      m_k[s]    = 0;
      e_led[s]  = 0;
    end
    m_age    = 0;
    m_door_e = 0;
    e_tens   = 0;
    e_ones   = 0;
    e_alarm  = 0;
  endtask

  task automatic model_edge();
    int  nm [2];
    bit  any_chg;
    bit  tick;
    int  n, rem;
    for (int s = 0; s < 2; s++) nm[s] = want_mode(s, turn_l, turn_r, brake);
    any_chg = (nm[0] != m_mode[0]) || (nm[1] != m_mode[1]);
    tick    = (m_age % TD) == (TD - 1);
    m_age   = any_chg ? 0 : m_age + 1;
    for (int s = 0; s < 2; s++) begin
      if (nm[s] != m_mode[s]) m_k[s] = 0;
      else if (tick)          m_k[s] = m_k[s] + 1;
      m_mode[s] = nm[s];
      case (m_mode[s])
        1: begin
          n = (m_k[s] + 1) % (LW + 1);
          e_led[s] = (1 << n) - 1;
        end
        2:       e_led[s] = ALL_ON;
        3:       e_led[s] = (m_k[s] % 2 == 0) ? ALL_ON : 0;
        default: e_led[s] = 0;
      endcase
    end
    if (door) begin
      m_door_e = m_door_e + 1;
      rem = DS - (m_door_e / SD);
      if (rem < 0) rem = 0;
      e_tens  = seg_tab[rem / 10];
      e_ones  = seg_tab[rem % 10];
      e_alarm = (rem == 0) ? 1 : 0;
    end else begin
      m_door_e = 0;
      e_tens   = 0;
      e_ones   = 0;
      e_alarm  = 0;
    end
  endtask

  // One transaction: apply inputs, clock, compare everything on the falling edge.
  task automatic cycle(input logic tl, input logic tr, input logic br, input logic dr);
    turn_l = tl;
    turn_r = tr;
    brake  = br;
    door   = dr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    $display("t=%0t in(tl tr br dr)=%b%b%b%b led_l=%b led_r=%b tens=%b ones=%b alarm=%b",
             $time, tl, tr, br, dr, led_l, led_r, seg_tens, seg_ones, door_alarm);
    chk("led_l",      32'(led_l),      32'(e_led[0]));
    chk("led_r",      32'(led_r),      32'(e_led[1]));
    chk("seg_tens",   32'(seg_tens),   32'(e_tens));
    chk("seg_ones",   32'(seg_ones),   32'(e_ones));
    chk("door_alarm", 32'(door_alarm), 32'(e_alarm));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic r_tl, r_tr, r_br, r_dr;

  initial begin
    model_reset();

    // Power-on reset: outputs zero before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_led_l", 32'(led_l), 32'd0);
    chk("rst_led_r", 32'(led_r), 32'd0);
    chk("rst_seg",   32'({seg_tens, seg_ones}), 32'd0);
    chk("rst_alarm", 32'(door_alarm), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Left flow from idle.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("flow_first_l", 32'(led_l), 32'b0001);
    chk("flow_first_r", 32'(led_r), 32'b0000);
    begin
      int seq [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
      for (int j = 0; j < 5; j++) begin
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("flow_step", 32'(led_l), 32'(seq[j]));
      end
    end
    idle(2);

    // Hazard blink.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("blink_on", 32'({led_l, led_r}), 32'hFF);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("blink_hold", 32'({led_l, led_r}), 32'hFF);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("blink_off", 32'({led_l, led_r}), 32'h00);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("blink_on2", 32'({led_l, led_r}), 32'hFF);
    idle(2);

    // Brake with right turn, then brake released.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("brake_solid_l", 32'(led_l), 32'b1111);
    chk("brake_flow_r",  32'(led_r), 32'b0001);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("brake_drop_l", 32'(led_l), 32'b0000);
    chk("brake_drop_r", 32'(led_r), 32'b0001);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("brake_drop_r2", 32'(led_r), 32'b0011);
    idle(2);

    // Door countdown down to the alarm, then closed.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("door_03", 32'({seg_tens, seg_ones}), 32'({7'b0111111, 7'b1001111}));
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("door_03_hold", 32'(seg_ones), 32'(7'b1001111));
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("door_02", 32'(seg_ones), 32'(7'b1011011));
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("door_01", 32'(seg_ones), 32'(7'b0000110));
    chk("door_01_noalarm", 32'(door_alarm), 32'd0);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("door_00", 32'(seg_ones), 32'(7'b0111111));
    chk("door_alarm", 32'(door_alarm), 32'd1);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("door_alarm_held", 32'({door_alarm, seg_ones}), 32'({1'b1, 7'b0111111}));
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("door_closed", 32'({door_alarm, seg_tens, seg_ones}), 32'd0);
    idle(1);

    // Flow interrupted at 0111 and re-requested: restarts with a full prescale.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_pre", 32'(led_l), 32'b0111);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_entry", 32'(led_l), 32'b0001);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_hold", 32'(led_l), 32'b0001);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_step", 32'(led_l), 32'b0011);

    // Asynchronous reset in the middle of activity.
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_led_l", 32'(led_l), 32'd0);
    chk("arst_seg",   32'({seg_tens, seg_ones}), 32'd0);
    chk("arst_alarm", 32'(door_alarm), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("arst_release_l", 32'(led_l), 32'b0001);

    // Randomized traffic: inputs held for random stretches.
    idle(1);
    r_tl = 1'b0; r_tr = 1'b0; r_br = 1'b0; r_dr = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0)  r_tl = ~r_tl;
      if ($urandom_range(0, 7) == 0)  r_tr = ~r_tr;
      if ($urandom_range(0, 5) == 0)  r_br = ~r_br;
      if ($urandom_range(0, 39) == 0) r_dr = ~r_dr;
      cycle(r_tl, r_tr, r_br, r_dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
